// File: rtl/lfsr_pattern_checker_if.sv
// Read-side bus between the LFSR pattern source and its checker.
// master: the checker (drives the active-low strobes, samples data).
// slave:  the pattern source.
interface lfsr_pattern_checker_if;
  logic [63:0] USER_DATA;
  logic        CEb;
  logic        OEb;
  logic        REb;

  modport master (output CEb, OEb, REb, input USER_DATA);
  modport slave  (input CEb, OEb, REb, output USER_DATA);
endinterface

// File: rtl/lfsr_pattern_checker.sv
// lfsr_pattern_checker: reads NWORDS words from the 64-bit LFSR pattern
// source, checks each word's field structure and its position in the
// 16-bit LFSR sequence, and reports word/error counts plus the first bad word.
// Words are captured on strobe-low edges and checked one cycle later.
// Optional build macro PATTERN_CHECK_STOP_ON_ERR_EN: the first error seen
// while locked stops issuing reads and ends the run early.
module lfsr_pattern_checker #(
  parameter int NW_WIDTH      = 24,
  parameter int ERR_WIDTH     = 16,
  parameter int RESYNC_THRESH = 4
) (
  input  logic                   CLK,
  input  logic                   RSTb,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [NW_WIDTH-1:0]    NWORDS,
  lfsr_pattern_checker_if.master src,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   LOCKED,
  output logic [NW_WIDTH-1:0]    WORD_COUNT,
  output logic [ERR_WIDTH-1:0]   ERR_COUNT,
  output logic [63:0]            FIRST_ERR
);
  localparam int CW = $clog2(RESYNC_THRESH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_FLUSH} state_t;

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v == 16'h8000) return 16'h0000;
    return {v[14:0], ~(v[15] ^ v[14] ^ v[12] ^ v[3])};
  endfunction

  state_t                state, state_nxt;
  logic                  rd_n, rd_n_nxt, done_nxt;
  logic                  chk_vld;
  logic [63:0]           chk_data;
  logic [NW_WIDTH-1:0]   rem;
  logic [15:0]           pred;
  logic [CW-1:0]         cerr;
  logic                  locked;
  logic                  err_seen;
  logic [NW_WIDTH-1:0]   wcnt;
  logic [ERR_WIDTH-1:0]  ecnt;
  logic [63:0]           ferr;

  logic [15:0] chk_x;
  logic        well_formed, bad, chk_good, chk_err, resync, last_iss, run_go;

  // Word check: structure always, sequence order only once locked.
  assign chk_x       = chk_data[63:48];
  assign well_formed = (chk_data[47:32] == bitrev16(chk_x)) &&
                       (chk_data[31:16] == ~bitrev16(chk_x)) &&
                       (chk_data[15:0]  == ~chk_x);
  assign bad         = !well_formed || (locked && (chk_x != pred));
  assign chk_good    = chk_vld && !bad;
  assign chk_err     = chk_vld && bad;
  assign resync      = chk_err && locked && (cerr == CW'(RESYNC_THRESH - 1));
  assign last_iss    = !rd_n && (rem == NW_WIDTH'(1));
  assign run_go      = (state == S_IDLE) && START && !ABORT && (NWORDS != '0);

  // State register.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, strobe and DONE control; ABORT overrides everything.
  always_comb begin
    state_nxt = state;
    rd_n_nxt  = rd_n;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          if (NWORDS == '0) done_nxt = 1'b1;
          else begin
            state_nxt = S_SEED;
            rd_n_nxt  = 1'b0;
          end
        end
      end
      S_SEED, S_RUN: begin
        if (chk_good && !locked) state_nxt = S_RUN;
        if (resync)              state_nxt = S_SEED;
`ifdef PATTERN_CHECK_STOP_ON_ERR_EN
        if (chk_err && locked) begin
          state_nxt = S_FLUSH;
          rd_n_nxt  = 1'b1;
        end
`endif
        if (last_iss) begin
          state_nxt = S_FLUSH;
          rd_n_nxt  = 1'b1;
        end
      end
      S_FLUSH: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (ABORT) begin
      state_nxt = S_IDLE;
      rd_n_nxt  = 1'b1;
      done_nxt  = (state != S_IDLE);
    end
  end

  // Strobes, capture register, predictor and run counters.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rd_n     <= 1'b1;
      DONE     <= 1'b0;
      chk_vld  <= 1'b0;
      chk_data <= '0;
      rem      <= '0;
      pred     <= '0;
      cerr     <= '0;
      locked   <= 1'b0;
      err_seen <= 1'b0;
      wcnt     <= '0;
      ecnt     <= '0;
      ferr     <= '0;
    end else begin
      rd_n    <= rd_n_nxt;
      DONE    <= done_nxt;
      // An abort drops the word captured on its edge as well.
      chk_vld <= !rd_n && !ABORT;
      if (!rd_n) begin
        chk_data <= src.USER_DATA;
        rem      <= rem - 1'b1;
      end
      if (run_go) begin
        rem      <= NWORDS;
        cerr     <= '0;
        locked   <= 1'b0;
        err_seen <= 1'b0;
        wcnt     <= '0;
        ecnt     <= '0;
        ferr     <= '0;
      end else if (chk_vld && !ABORT) begin
        wcnt <= wcnt + 1'b1;
        if (bad) begin
          if (ecnt != '1) ecnt <= ecnt + 1'b1;
          if (!err_seen) begin
            ferr     <= chk_data;
            err_seen <= 1'b1;
          end
          // Locked: keep the predictor free-running so a single bad word
          // does not lose sequence position.
          if (locked) begin
            pred <= lfsr_next(pred);
            if (resync) begin
              locked <= 1'b0;
              cerr   <= '0;
            end else begin
              cerr <= cerr + 1'b1;
            end
          end
        end else begin
          pred   <= lfsr_next(chk_x);
          locked <= 1'b1;
          cerr   <= '0;
        end
      end
    end
  end

  assign src.CEb    = rd_n;
  assign src.OEb    = rd_n;
  assign src.REb    = rd_n;
  assign BUSY       = (state != S_IDLE);
  assign LOCKED     = locked;
  assign WORD_COUNT = wcnt;
  assign ERR_COUNT  = ecnt;
  assign FIRST_ERR  = ferr;
endmodule

// File: tb/tb_lfsr_pattern_checker.sv
// Bench for lfsr_pattern_checker: behavioural pattern source, a sequence-level
// model of the expected counts, a per-cycle compare process and directed runs.
module tb_lfsr_pattern_checker;
  localparam int NW = 24;
  localparam int EW = 16;
  localparam int TH = 4;

  logic          CLK = 1'b0;
  logic          RSTb, START, ABORT;
  logic [NW-1:0] NWORDS;
  logic          BUSY, DONE, LOCKED;
  logic [NW-1:0] WORD_COUNT;
  logic [EW-1:0] ERR_COUNT;
  logic [63:0]   FIRST_ERR;

  lfsr_pattern_checker_if src_if();

  lfsr_pattern_checker #(.NW_WIDTH(NW), .ERR_WIDTH(EW), .RESYNC_THRESH(TH)) dut (
    .CLK(CLK), .RSTb(RSTb), .START(START), .ABORT(ABORT), .NWORDS(NWORDS),
    .src(src_if.master), .BUSY(BUSY), .DONE(DONE), .LOCKED(LOCKED),
    .WORD_COUNT(WORD_COUNT), .ERR_COUNT(ERR_COUNT), .FIRST_ERR(FIRST_ERR));

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] nxt16(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h0000 : {x[14:0], ~(x[15] ^ x[14] ^ x[12] ^ x[3])};
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = x[i];
    return r;
  endfunction

  function automatic logic [63:0] mkword(input logic [15:0] x);
    return {x, rev16(x), ~rev16(x), ~x};
  endfunction

  // Pattern source: advances whenever strobes are low; optional corruption
  // of one word and an optional sequence jump, both by absolute word index.
  logic [15:0] src_x;
  bit          ld_req = 0;
  logic [15:0] ld_val = '0;
  int          corr_idx = -1, jump_idx = -1;
  logic [63:0] corr_mask = '0;
  logic [15:0] jump_val = '0;
  int          consumed = 0, cons_d = 0, base = 0;
  logic [63:0] words [0:4095];
  bit          chk_en = 0;

  always_comb src_if.USER_DATA = mkword(src_x) ^ ((consumed == corr_idx) ? corr_mask : 64'h0);

  always @(posedge CLK) begin
    if (ld_req) src_x <= ld_val;
    else if (!src_if.CEb && !src_if.OEb)
      src_x <= (consumed + 1 == jump_idx) ? jump_val : nxt16(src_x);
    if (!src_if.CEb && !src_if.OEb) begin
      words[consumed] <= src_if.USER_DATA;
      consumed        <= consumed + 1;
    end
    cons_d <= consumed;
  end

  // Expected results after the checker has judged the first n words of a run.
  task automatic model(input int n, output int wc, output int ec, output logic [63:0] fe, output bit lk);
    logic [15:0] p, x;
    logic [63:0] w;
    bit          wf, err;
    int          consec;
    wc = n; ec = 0; fe = '0; lk = 0; p = '0; consec = 0;
    for (int k = 0; k < n; k++) begin
      w   = words[base + k];
      x   = w[63:48];
      wf  = (w == mkword(x));
      err = !wf || (lk && x != p);
      if (err) begin
        if (ec == 0) fe = w;
        if (ec < 65535) ec++;
        if (lk) begin
          p = nxt16(p);
          consec++;
          if (consec == TH) begin lk = 0; consec = 0; end
        end
      end else begin
        p = nxt16(x); lk = 1; consec = 0;
      end
    end
  endtask

  int          m_wc, m_ec;
  logic [63:0] m_fe;
  bit          m_lk;

  // Per-cycle compare against the model while a run's outputs are live.
  always @(negedge CLK) begin
    if (RSTb) begin
      chk("strobe_eq", 64'(src_if.CEb == src_if.OEb && src_if.OEb == src_if.REb), 64'd1);
      if (chk_en && (BUSY || DONE)) begin
        model(cons_d - base, m_wc, m_ec, m_fe, m_lk);
        chk("cyc_word_count", 64'(WORD_COUNT), 64'(m_wc));
        chk("cyc_err_count",  64'(ERR_COUNT),  64'(m_ec));
        chk("cyc_first_err",  FIRST_ERR,       m_fe);
        chk("cyc_locked",     64'(LOCKED),     64'(m_lk));
      end
    end
  end

  bit r_got, r_drop;
  int r_lat;

  task automatic load(input logic [15:0] v);
    @(negedge CLK); ld_req = 1; ld_val = v;
    @(negedge CLK); ld_req = 0;
  endtask

  task automatic run(input int n, input int tmo);
    bit seen_lk;
    @(negedge CLK);
    base = consumed; NWORDS = NW'(n); START = 1; chk_en = (n != 0);
    @(negedge CLK);
    START = 0;
    r_got = 0; r_lat = 0; r_drop = 0; seen_lk = 0;
    for (int i = 0; i < tmo; i++) begin
      if (LOCKED) seen_lk = 1; else if (seen_lk) r_drop = 1;
      if (DONE) begin r_got = 1; r_lat = i; break; end
      @(negedge CLK);
    end
    chk_en = 0;
  endtask

  initial begin
    RSTb = 0; START = 0; ABORT = 0; NWORDS = '0;
    repeat (2) @(negedge CLK);
    chk("rst_CEb", 64'(src_if.CEb), 64'd1);
    chk("rst_busy_done_lock", 64'({BUSY, DONE, LOCKED}), 64'd0);
    chk("rst_counts", 64'({WORD_COUNT, ERR_COUNT}), 64'd0);
    chk("rst_first_err", FIRST_ERR, 64'd0);
    RSTb = 1;

    // Basic run from x=0.
    load(16'h0000);
    run(4, 40);
    chk("t1_done", 64'(r_got), 64'd1);
    chk("t1_wc", 64'(WORD_COUNT), 64'd4);
    chk("t1_ec", 64'(ERR_COUNT), 64'd0);
    chk("t1_locked", 64'(LOCKED), 64'd1);
    chk("t1_strobes", 64'(consumed - base), 64'd4);
    chk("t1_word0", words[base], 64'h00000000FFFFFFFF);
    chk("t1_word1", words[base+1], 64'h000180007FFFFFFE);
    chk("t1_word3_x", 64'(words[base+3][63:48]), 64'h0007);

    // 0x8000 -> 0x0000 wrap.
    load(16'h4000);
    run(4, 40);
    chk("t2_done", 64'(r_got), 64'd1);
    chk("t2_wc", 64'(WORD_COUNT), 64'd4);
    chk("t2_ec", 64'(ERR_COUNT), 64'd0);
    chk("t2_word2", words[base+2], 64'h0000_0000_FFFF_FFFF);

    // Single corrupted word (3rd of 16).
    load(16'h0000);
    corr_idx = consumed + 2; corr_mask = 64'h1 << 20;
    run(16, 80);
    corr_idx = -1;
    chk("t3_done", 64'(r_got), 64'd1);
    chk("t3_ec", 64'(ERR_COUNT), 64'd1);
    chk("t3_first_err", FIRST_ERR, 64'h0003C0003FEFFFFC);
    chk("t3_locked", 64'(LOCKED), 64'd1);
`ifdef PATTERN_CHECK_STOP_ON_ERR_EN
    chk("t3_wc", 64'(WORD_COUNT), 64'd4);
`else
    chk("t3_wc", 64'(WORD_COUNT), 64'd16);
`endif

    // Sequence jump at word 5 of 30.
    load(16'h0000);
    jump_idx = consumed + 4; jump_val = 16'h1234;
    run(30, 120);
    jump_idx = -1;
    chk("t4_done", 64'(r_got), 64'd1);
    chk("t4_first_err_x", 64'(FIRST_ERR[63:48]), 64'h1234);
`ifdef PATTERN_CHECK_STOP_ON_ERR_EN
    chk("t4_ec", 64'(ERR_COUNT), 64'd2);
    chk("t4_wc", 64'(WORD_COUNT), 64'd6);
    chk("t4_lock_drop", 64'(r_drop), 64'd0);
`else
    chk("t4_ec", 64'(ERR_COUNT), 64'd4);
    chk("t4_wc", 64'(WORD_COUNT), 64'd30);
    chk("t4_lock_drop", 64'(r_drop), 64'd1);
    chk("t4_relocked", 64'(LOCKED), 64'd1);
`endif

    // NWORDS = 0: immediate DONE, no reads.
    run(0, 10);
    chk("t5_done", 64'(r_got), 64'd1);
    chk("t5_latency", 64'(r_lat), 64'd0);
    chk("t5_strobes", 64'(consumed - base), 64'd0);

    // Corrupt word 7 of 50 (stop-on-error behaviour differs).
    load(16'h0000);
    corr_idx = consumed + 6; corr_mask = 64'h1;
    run(50, 200);
    corr_idx = -1;
    chk("t6_done", 64'(r_got), 64'd1);
    chk("t6_ec", 64'(ERR_COUNT), 64'd1);
`ifdef PATTERN_CHECK_STOP_ON_ERR_EN
    chk("t6_wc", 64'(WORD_COUNT), 64'd8);
    chk("t6_strobes", 64'(consumed - base), 64'd8);
`else
    chk("t6_wc", 64'(WORD_COUNT), 64'd50);
    chk("t6_strobes", 64'(consumed - base), 64'd50);
`endif

    // ABORT at word 10 of 100.
    load(16'h0000);
    @(negedge CLK);
    base = consumed; NWORDS = NW'(100); START = 1; chk_en = 1;
    @(negedge CLK);
    START = 0;
    for (int i = 0; i < 50 && consumed - base < 10; i++) @(negedge CLK);
    chk("t7_reached10", 64'(consumed - base), 64'd10);
    chk_en = 0; ABORT = 1;
    @(negedge CLK);
    ABORT = 0;
    chk("t7_CEb", 64'(src_if.CEb), 64'd1);
    chk("t7_done", 64'(DONE), 64'd1);
    chk("t7_busy", 64'(BUSY), 64'd0);
    chk("t7_wc_le10", 64'(WORD_COUNT <= 10), 64'd1);
    @(negedge CLK);
    chk("t7_done_pulse", 64'(DONE), 64'd0);
    chk("t7_strobes", 64'(consumed - base), 64'd11);

    // START while busy is ignored: a second START mid-run must not restart.
    load(16'h0000);
    @(negedge CLK);
    base = consumed; NWORDS = NW'(12); START = 1; chk_en = 1;
    @(negedge CLK); START = 0;
    repeat (4) @(negedge CLK);
    NWORDS = NW'(3); START = 1;
    @(negedge CLK); START = 0;
    for (int i = 0; i < 40 && !DONE; i++) @(negedge CLK);
    chk_en = 0;
    chk("t8_done", 64'(DONE), 64'd1);
    chk("t8_wc", 64'(WORD_COUNT), 64'd12);

    // Reset mid-run.
    load(16'h0000);
    @(negedge CLK);
    NWORDS = NW'(40); START = 1;
    @(negedge CLK); START = 0;
    repeat (5) @(negedge CLK);
    #2 RSTb = 0;
    #1;
    chk("t9_CEb", 64'(src_if.CEb), 64'd1);
    chk("t9_flags", 64'({BUSY, DONE, LOCKED}), 64'd0);
    chk("t9_counts", 64'({WORD_COUNT, ERR_COUNT}), 64'd0);
    chk("t9_first_err", FIRST_ERR, 64'd0);
    @(negedge CLK); RSTb = 1;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
